// File: rtl/window_feeder.sv
// ----------------------------------------------------------------------------
// window_feeder
//
// Purpose:
//   Turns a raster-order pixel stream into SIZE x SIZE sliding windows for a
//   downstream convolution stage. SIZE-1 previous rows are kept in line
//   buffers so each window is built from the stream without refetching any
//   pixel. A window is issued only when it lies fully inside the frame, so
//   no padding is used. While a window is waiting to be consumed, the input
//   is stalled and the window is held stable.
//
// Ports:
//   clk           - sole clock, rising edge
//   n_rst         - asynchronous active-low reset
//   pixel_in      - 8-bit pixel, row-major, top-left first
//   pixel_valid   - pixel_in is valid this cycle
//   pixel_ready   - block accepts pixel_in this cycle
//   kernel_done   - one-cycle pulse: the issued window has been consumed
//   input_matrix  - current window, [r][c] = frame(row-SIZE+1+r, col-SIZE+1+c)
//   start         - one-cycle pulse: input_matrix holds a fresh window
//   frame_done    - one-cycle pulse after the last window of a frame is consumed
// ----------------------------------------------------------------------------
module window_feeder #(
    parameter int SIZE  = 3,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic [7:0]                      pixel_in,
    input  logic                            pixel_valid,
    output logic                            pixel_ready,
    input  logic                            kernel_done,
    output logic [SIZE-1:0][SIZE-1:0][7:0]  input_matrix,
    output logic                            start,
    output logic                            frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_EDGE = CW'(SIZE - 1);
    localparam logic [RW-1:0] ROW_EDGE = RW'(SIZE - 1);

    typedef enum logic [1:0] {
        ACCEPT,
        ISSUE,
        WAIT
    } state_t;

    state_t                          state_q;
    logic [CW-1:0]                   col_q, col_d;
    logic [RW-1:0]                   row_q, row_d;
    logic                            ready_q;
    logic                            start_q;
    logic                            frameDone_q;
    logic                            lastWindow_q;
    logic [SIZE-1:0][SIZE-1:0][7:0]  window_q, window_d;
    logic [SIZE-1:0][7:0]            newCol_d;

    // lineBuf_q[0] holds the oldest buffered row, lineBuf_q[SIZE-2] the row
    // directly above the pixel currently arriving.
    logic [7:0]                      lineBuf_q [SIZE-1][IMG_W];

    logic                            transfer;
    logic                            winComplete;
    logic                            lastPixel;

    assign transfer    = pixel_valid && (state_q == ACCEPT);
    assign winComplete = (row_q >= ROW_EDGE) && (col_q >= COL_EDGE);
    assign lastPixel   = (row_q == ROW_LAST) && (col_q == COL_LAST);

    assign pixel_ready  = ready_q;
    assign start        = start_q;
    assign frame_done   = frameDone_q;
    assign input_matrix = window_q;

    // Raster position of the next accepted pixel: column wraps into the next
    // row, and the final pixel of the frame wraps everything back to (0,0).
    always_comb begin
        col_d = col_q + CW'(1);
        row_d = row_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end
    end

    // New right-hand column of the window: buffered rows on top, the live
    // pixel at the bottom. The window itself slides one column to the left.
    always_comb begin
        newCol_d = '0;
        for (int r = 0; r < SIZE - 1; r++) begin
            newCol_d[r] = lineBuf_q[r][col_q];
        end
        newCol_d[SIZE-1] = pixel_in;

        window_d = window_q;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE - 1; c++) begin
                window_d[r][c] = window_q[r][c+1];
            end
            window_d[r][SIZE-1] = newCol_d[r];
        end
    end

    // Line buffers have no reset: each column shifts up by one row on every
    // accepted pixel. Stale contents only ever sit in rows that are not yet
    // part of an interior window, so they never reach an issued window.
    always_ff @(posedge clk) begin
        if (transfer) begin
            for (int k = 0; k < SIZE - 1; k++) begin
                lineBuf_q[k][col_q] <= newCol_d[k+1];
            end
        end
    end

    // Control FSM with registered handshake outputs. lastWindow_q remembers
    // whether the window in flight closes the frame, so frame_done can fire
    // once that window is consumed.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ACCEPT;
            col_q        <= '0;
            row_q        <= '0;
            ready_q      <= 1'b1;
            start_q      <= 1'b0;
            frameDone_q  <= 1'b0;
            lastWindow_q <= 1'b0;
            window_q     <= '0;
        end else begin
            start_q     <= 1'b0;
            frameDone_q <= 1'b0;
            case (state_q)
                ACCEPT: begin
                    if (pixel_valid) begin
                        col_q    <= col_d;
                        row_q    <= row_d;
                        window_q <= window_d;
                        if (winComplete) begin
                            state_q      <= ISSUE;
                            start_q      <= 1'b1;
                            ready_q      <= 1'b0;
                            lastWindow_q <= lastPixel;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (kernel_done) begin
                        state_q     <= ACCEPT;
                        ready_q     <= 1'b1;
                        frameDone_q <= lastWindow_q;
                    end
                end
                default: begin
                    state_q <= ACCEPT;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_feeder.sv
// ----------------------------------------------------------------------------
// tb_window_feeder
//
// Purpose:
//   Self-checking bench for window_feeder with SIZE=3 on a 4x4 frame. A
//   behavioural model stores every accepted pixel of the frame in an array
//   indexed by raster position and derives the expected handshake and the
//   expected window directly from that picture of the frame.
// ----------------------------------------------------------------------------
module tb_window_feeder;

    localparam int SIZE = 3;
    localparam int W    = 4;
    localparam int H    = 4;

    logic                            clk = 1'b0;
    logic                            n_rst;
    logic [7:0]                      pixel_in;
    logic                            pixel_valid;
    logic                            pixel_ready;
    logic                            kernel_done;
    logic [SIZE-1:0][SIZE-1:0][7:0]  input_matrix;
    logic                            start;
    logic                            frame_done;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic                            expReady;
    logic                            expStart;
    logic                            expFd;
    logic                            lastPending;
    int                              pos;
    logic [7:0]                      img [W*H];
    logic [SIZE-1:0][SIZE-1:0][7:0]  expWin;

    // Windows seen on the DUT, kept for checks against fixed frame contents
    logic [SIZE-1:0][SIZE-1:0][7:0]  firstStartWin;
    logic [SIZE-1:0][SIZE-1:0][7:0]  lastStartWin;

    window_feeder #(
        .SIZE (SIZE),
        .IMG_W(W),
        .IMG_H(H)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .kernel_done (kernel_done),
        .input_matrix(input_matrix),
        .start       (start),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    function automatic void resetModel();
        expReady    = 1'b1;
        expStart    = 1'b0;
        expFd       = 1'b0;
        lastPending = 1'b0;
        pos         = 0;
        expWin      = '0;
    endfunction

    // Window expected for frame pixel k = k, anchored at top-left (r0,c0)
    function automatic logic [SIZE-1:0][SIZE-1:0][7:0] rampWindow(input int r0, input int c0);
        logic [SIZE-1:0][SIZE-1:0][7:0] w;
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                w[i][j] = 8'((r0 + i) * W + c0 + j);
        return w;
    endfunction

    task automatic pulseReset();
        @(negedge clk);
        n_rst       = 1'b0;
        pixel_valid = 1'b0;
        kernel_done = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        resetModel();
    endtask

    // Streams nPix pixels, answering each start with kernel_done kdDelay
    // cycles later, and checks the handshake every cycle plus the window
    // whenever one is issued or held. With stopWait set it returns while the
    // last window is still unconsumed.
    task automatic streamFrame(input int nPix, input int kdDelay, input bit gaps,
                               input bit randPix, input bit spurious, input bit stopWait,
                               output int nStarts, output int nFd);
        logic [7:0] vals [64];
        int         src;
        int         kdTimer;
        int         cycles;
        int         waited;
        int         r;
        int         c;
        bit         v;
        bit         kd;
        logic       nReady;
        logic       nStart;
        logic       nFdN;
        src     = 0;
        kdTimer = -1;
        cycles  = 0;
        waited  = 0;
        nStarts = 0;
        nFd     = 0;
        for (int i = 0; i < nPix; i++)
            vals[i] = randPix ? 8'($urandom) : 8'(pos + i);
        forever begin
            @(negedge clk);
            vectors += 3;
            if (pixel_ready !== expReady) begin
                errors++;
                $display("[TB] FAIL pixel_ready at pos %0d: got %b expected %b", pos, pixel_ready, expReady);
            end
            if (start !== expStart) begin
                errors++;
                $display("[TB] FAIL start at pos %0d: got %b expected %b", pos, start, expStart);
            end
            if (frame_done !== expFd) begin
                errors++;
                $display("[TB] FAIL frame_done at pos %0d: got %b expected %b", pos, frame_done, expFd);
            end
            if (expStart || !expReady) begin
                vectors++;
                if (input_matrix !== expWin) begin
                    errors++;
                    $display("[TB] FAIL window at pos %0d: got %h expected %h", pos, input_matrix, expWin);
                end
            end
            if (start === 1'b1) begin
                if (nStarts == 0) firstStartWin = input_matrix;
                lastStartWin = input_matrix;
                nStarts++;
            end
            if (frame_done === 1'b1) nFd++;

            if (src == nPix && !expReady && !expStart) waited++;
            if ((src == nPix && expReady && !expFd && kdTimer < 0) || (stopWait && waited >= 5)) begin
                pixel_valid = 1'b0;
                kernel_done = 1'b0;
                break;
            end
            cycles++;
            if (cycles > 3000) begin
                vectors++;
                errors++;
                $display("[TB] FAIL timeout: got %0d of %0d pixels accepted", src, nPix);
                pixel_valid = 1'b0;
                kernel_done = 1'b0;
                break;
            end

            v  = (src < nPix) && (!gaps || $urandom_range(0, 2) != 0);
            kd = 1'b0;
            if (expStart) begin
                kdTimer = stopWait ? -1 : kdDelay;
            end else if (kdTimer > 0) begin
                kdTimer--;
                if (kdTimer == 0) begin
                    kd      = 1'b1;
                    kdTimer = -1;
                end
            end
            if (spurious && expReady && $urandom_range(0, 3) == 0) kd = 1'b1;
            pixel_valid = v;
            pixel_in    = (src < nPix) ? vals[src] : 8'($urandom);
            kernel_done = kd;

            nReady = expReady;
            nStart = 1'b0;
            nFdN   = 1'b0;
            if (expReady && v) begin
                img[pos] = pixel_in;
                r = pos / W;
                c = pos % W;
                src++;
                if (r >= SIZE - 1 && c >= SIZE - 1) begin
                    nStart      = 1'b1;
                    nReady      = 1'b0;
                    lastPending = (pos == W * H - 1);
                    for (int i = 0; i < SIZE; i++)
                        for (int j = 0; j < SIZE; j++)
                            expWin[i][j] = img[(r - SIZE + 1 + i) * W + (c - SIZE + 1 + j)];
                end
                pos = (pos + 1) % (W * H);
            end else if (!expReady && !expStart && kd) begin
                nReady = 1'b1;
                nFdN   = lastPending;
            end
            expReady = nReady;
            expStart = nStart;
            expFd    = nFdN;
        end
    endtask

    task automatic test_reset();
        n_rst       = 1'b0;
        pixel_valid = 1'b1;
        pixel_in    = 8'hA5;
        kernel_done = 1'b0;
        repeat (2) @(negedge clk);
        vectors += 4;
        if (pixel_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset pixel_ready: got %b expected 1", pixel_ready); end
        if (start !== 1'b0) begin errors++; $display("[TB] FAIL reset start: got %b expected 0", start); end
        if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset frame_done: got %b expected 0", frame_done); end
        if (input_matrix !== '0) begin errors++; $display("[TB] FAIL reset window: got %h expected 0", input_matrix); end
        pixel_valid = 1'b0;
        n_rst       = 1'b1;
        resetModel();
    endtask

    task automatic test_first_window();
        int ns, nf;
        pulseReset();
        streamFrame(11, 1, 0, 0, 0, 0, ns, nf);
        vectors += 2;
        if (ns !== 1) begin errors++; $display("[TB] FAIL first_window starts: got %0d expected 1", ns); end
        if (firstStartWin !== rampWindow(0, 0)) begin
            errors++;
            $display("[TB] FAIL first_window contents: got %h expected %h", firstStartWin, rampWindow(0, 0));
        end
    endtask

    task automatic test_full_frame();
        int ns, nf;
        pulseReset();
        streamFrame(16, 3, 0, 0, 0, 0, ns, nf);
        vectors += 3;
        if (ns !== 4) begin errors++; $display("[TB] FAIL full_frame starts: got %0d expected 4", ns); end
        if (nf !== 1) begin errors++; $display("[TB] FAIL full_frame frame_done: got %0d expected 1", nf); end
        if (lastStartWin !== rampWindow(1, 1)) begin
            errors++;
            $display("[TB] FAIL full_frame last window: got %h expected %h", lastStartWin, rampWindow(1, 1));
        end
    endtask

    task automatic test_stall();
        int ns, nf;
        pulseReset();
        streamFrame(16, 20, 0, 1, 0, 0, ns, nf);
        vectors += 2;
        if (ns !== 4) begin errors++; $display("[TB] FAIL stall starts: got %0d expected 4", ns); end
        if (nf !== 1) begin errors++; $display("[TB] FAIL stall frame_done: got %0d expected 1", nf); end
    endtask

    task automatic test_kernel_done_in_accept();
        int ns, nf;
        pulseReset();
        streamFrame(16, 2, 1, 1, 1, 0, ns, nf);
        vectors += 2;
        if (ns !== 4) begin errors++; $display("[TB] FAIL spurious_kd starts: got %0d expected 4", ns); end
        if (nf !== 1) begin errors++; $display("[TB] FAIL spurious_kd frame_done: got %0d expected 1", nf); end
    endtask

    task automatic test_reset_mid_wait();
        int ns, nf;
        pulseReset();
        streamFrame(11, 1, 0, 0, 0, 0, ns, nf);
        streamFrame(1, 1, 0, 0, 0, 1, ns, nf);
        vectors++;
        if (ns !== 1) begin errors++; $display("[TB] FAIL mid_wait second start: got %0d expected 1", ns); end
        n_rst       = 1'b0;
        pixel_valid = 1'b1;
        pixel_in    = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors += 4;
            if (pixel_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_wait reset pixel_ready: got %b expected 1", pixel_ready); end
            if (start !== 1'b0) begin errors++; $display("[TB] FAIL mid_wait reset start: got %b expected 0", start); end
            if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_wait reset frame_done: got %b expected 0", frame_done); end
            if (input_matrix !== '0) begin errors++; $display("[TB] FAIL mid_wait reset window: got %h expected 0", input_matrix); end
        end
        pixel_valid = 1'b0;
        n_rst       = 1'b1;
        resetModel();
        streamFrame(16, 1, 0, 0, 0, 0, ns, nf);
        vectors += 3;
        if (ns !== 4) begin errors++; $display("[TB] FAIL mid_wait fresh starts: got %0d expected 4", ns); end
        if (nf !== 1) begin errors++; $display("[TB] FAIL mid_wait fresh frame_done: got %0d expected 1", nf); end
        if (firstStartWin !== rampWindow(0, 0)) begin
            errors++;
            $display("[TB] FAIL mid_wait first window: got %h expected %h", firstStartWin, rampWindow(0, 0));
        end
    endtask

    task automatic test_back_to_back();
        int ns, nf;
        pulseReset();
        streamFrame(32, int'($urandom_range(1, 4)), 1, 1, 0, 0, ns, nf);
        vectors += 2;
        if (ns !== 8) begin errors++; $display("[TB] FAIL back_to_back starts: got %0d expected 8", ns); end
        if (nf !== 2) begin errors++; $display("[TB] FAIL back_to_back frame_done: got %0d expected 2", nf); end
    endtask

    // Scenarios run in sequence; each one brings its own reset so a failure
    // in one does not cascade into the next.
    initial begin
        resetModel();
        test_reset();
        test_first_window();
        test_full_frame();
        test_stall();
        test_kernel_done_in_accept();
        test_reset_mid_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
